// File: rtl/dpwm_pkg.sv
// Shared constants for the DPWM parameter loader: selector codes, reset
// defaults and the debounce state encoding.
package dpwm_pkg;

    localparam logic [1:0] SEL_DC  = 2'b00;
    localparam logic [1:0] SEL_FS  = 2'b01;
    localparam logic [1:0] SEL_DT1 = 2'b10;
    localparam logic [1:0] SEL_DT2 = 2'b11;

    // Period resets to all-ones (longest period); duty to zero.
    localparam int DEFAULT_DUTY_WORD = 0;
    localparam int DEFAULT_DT_WORD   = 4;

    typedef enum logic [1:0] {
        DB_RELEASED     = 2'b00,
        DB_PRESS_QUAL   = 2'b01,
        DB_PRESSED      = 2'b10,
        DB_RELEASE_QUAL = 2'b11
    } db_state_e;

endpackage

// File: rtl/dpwm_param_loader_key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, press/release qualification FSM
// and a single-cycle pulse on every qualified press.
module key_debounce
    import dpwm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    db_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            key_low;

    assign key_low = ~sync2_q;

    always_comb begin
        sync1_d     = key_n;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_pulse = 1'b0;
        case (state_q)
            DB_RELEASED: begin
                if (key_low) begin
                    state_d = DB_PRESS_QUAL;
                    cnt_d   = '0;
                end
            end
            DB_PRESS_QUAL: begin
                if (!key_low) begin
                    state_d = DB_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = DB_PRESSED;
                    cnt_d       = '0;
                    press_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DB_PRESSED: begin
                if (!key_low) begin
                    state_d = DB_RELEASE_QUAL;
                    cnt_d   = '0;
                end
            end
            DB_RELEASE_QUAL: begin
                // A low glitch while qualifying release means the key is still held.
                if (key_low) begin
                    state_d = DB_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DB_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= DB_RELEASED;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/dpwm_param_loader.sv
// Stages DPWM control words one button press at a time and commits the whole
// set atomically at a period boundary if it is self-consistent.
module dpwm_param_loader
    import dpwm_pkg::*;
#(
    parameter int RESOLUTION      = 12,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEFAULT_DT      = DEFAULT_DT_WORD
) (
    input  logic                  hf_clock,
    input  logic                  reset,
    input  logic [1:0]            sel,
    input  logic [RESOLUTION-1:0] value,
    input  logic                  load_n,
    input  logic                  period_end,
    output logic [RESOLUTION-1:0] duty_cycle,
    output logic [RESOLUTION-1:0] fs,
    output logic [RESOLUTION-1:0] deadtime1,
    output logic [RESOLUTION-1:0] deadtime2,
    output logic                  pending,
    output logic                  reject
);

    typedef logic [RESOLUTION-1:0] word_t;

    function automatic word_t default_word(input logic [1:0] idx);
        case (idx)
            SEL_DC:  return RESOLUTION'(DEFAULT_DUTY_WORD);
            SEL_FS:  return {RESOLUTION{1'b1}};
            default: return RESOLUTION'(DEFAULT_DT);
        endcase
    endfunction

    word_t active_q [4];
    word_t active_d [4];
    word_t shadow_q [4];
    word_t shadow_d [4];
    logic  pending_q, pending_d;
    logic  reject_q, reject_d;
    logic  stage;
    logic  commit;
    logic  set_valid;
    logic [RESOLUTION:0] dt_sum;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (hf_clock),
        .reset      (reset),
        .key_n      (load_n),
        .press_pulse(stage)
    );

    // One extra bit so two large deadtimes cannot wrap into a small sum.
    assign dt_sum    = {1'b0, shadow_q[SEL_DT1]} + {1'b0, shadow_q[SEL_DT2]};
    assign set_valid = (shadow_q[SEL_FS] != '0) &&
                       (shadow_q[SEL_DC] <= shadow_q[SEL_FS]) &&
                       (dt_sum < {1'b0, shadow_q[SEL_FS]});
    // A press in the same cycle as the boundary takes priority; commit waits a period.
    assign commit    = period_end && pending_q && !stage;

    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        reject_d  = 1'b0;
        if (stage) begin
            shadow_d[sel] = value;
            pending_d     = 1'b1;
        end else if (commit) begin
            pending_d = 1'b0;
            if (set_valid) begin
                active_d = shadow_q;
            end else begin
                shadow_d = active_q;
                reject_d = 1'b1;
            end
        end
    end

    always_ff @(posedge hf_clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                active_q[i] <= default_word(2'(i));
                shadow_q[i] <= default_word(2'(i));
            end
            pending_q <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            reject_q  <= reject_d;
        end
    end

    assign duty_cycle = active_q[SEL_DC];
    assign fs         = active_q[SEL_FS];
    assign deadtime1  = active_q[SEL_DT1];
    assign deadtime2  = active_q[SEL_DT2];
    assign pending    = pending_q;
    assign reject     = reject_q;

endmodule

// File: tb/tb_dpwm_param_loader.sv
// Randomised and directed bench for dpwm_param_loader against a run-length
// button model and an array-based staging/commit model.
module tb_dpwm_param_loader;

    localparam int RES = 12;
    localparam int DEB = 4;

    logic            hf_clock = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      sel = 2'b00;
    logic [RES-1:0]  value = '0;
    logic            load_n = 1'b1;
    logic            period_end = 1'b0;
    logic [RES-1:0]  duty_cycle, fs, deadtime1, deadtime2;
    logic            pending, reject;

    int n_vec = 0;
    int n_err = 0;

    // Model state: word index 0 duty, 1 fs, 2 dt1, 3 dt2.
    int m_active[4];
    int m_shadow[4];
    bit m_pending, m_reject;
    bit m_s1, m_s2, m_pressed;
    int m_run;

    dpwm_param_loader #(
        .RESOLUTION     (RES),
        .DEBOUNCE_CYCLES(DEB),
        .DEFAULT_DT     (4)
    ) dut (
        .hf_clock  (hf_clock),
        .reset     (reset),
        .sel       (sel),
        .value     (value),
        .load_n    (load_n),
        .period_end(period_end),
        .duty_cycle(duty_cycle),
        .fs        (fs),
        .deadtime1 (deadtime1),
        .deadtime2 (deadtime2),
        .pending   (pending),
        .reject    (reject)
    );

    always #5 hf_clock = ~hf_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // The button is accepted as pressed (or released) once the synchronised
    // level has disagreed with the current debounced level for DEB+1 edges.
    task automatic model_edge(input bit rst, input bit ln, input int s, input int v, input bit pe);
        bit synced;
        bit staged;
        int sum;
        if (rst) begin
            m_active  = '{0, 4095, 4, 4};
            m_shadow  = '{0, 4095, 4, 4};
            m_pending = 0;
            m_reject  = 0;
            m_s1      = 1;
            m_s2      = 1;
            m_pressed = 0;
            m_run     = 0;
        end else begin
            synced = m_s2;
            staged = 0;
            if (m_pressed ? synced : !synced) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_pressed = !m_pressed;
                    m_run     = 0;
                    staged    = m_pressed;
                end
            end else begin
                m_run = 0;
            end
            m_s2     = m_s1;
            m_s1     = ln;
            m_reject = 0;
            if (staged) begin
                m_shadow[s] = v;
                m_pending   = 1;
            end else if (pe && m_pending) begin
                sum = m_shadow[2] + m_shadow[3];
                if (m_shadow[1] != 0 && m_shadow[0] <= m_shadow[1] && sum < m_shadow[1])
                    m_active = m_shadow;
                else begin
                    m_shadow = m_active;
                    m_reject = 1;
                end
                m_pending = 0;
            end
        end
    endtask

    task automatic step(input bit rst, input bit ln, input int s, input int v, input bit pe);
        reset      = rst;
        load_n     = ln;
        sel        = 2'(s);
        value      = RES'(v);
        period_end = pe;
        @(posedge hf_clock);
        model_edge(rst, ln, s, v, pe);
        #1;
        check("duty_cycle", 32'(duty_cycle), 32'(m_active[0]));
        check("fs", 32'(fs), 32'(m_active[1]));
        check("deadtime1", 32'(deadtime1), 32'(m_active[2]));
        check("deadtime2", 32'(deadtime2), 32'(m_active[3]));
        check("pending", 32'(pending), 32'(m_pending));
        check("reject", 32'(reject), 32'(m_reject));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
    endtask

    task automatic press(input int s, input int v);
        for (int i = 0; i < 8; i++) step(0, 0, s, v, 0);
        idle(8);
    endtask

    task automatic boundary();
        step(0, 1, 0, 0, 1);
    endtask

    initial begin
        // 1: reset state
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("t1_duty", 32'(duty_cycle), 32'd0);
        check("t1_fs", 32'(fs), 32'd4095);
        check("t1_dt1", 32'(deadtime1), 32'd4);
        check("t1_dt2", 32'(deadtime2), 32'd4);
        check("t1_pending", 32'(pending), 32'd0);
        check("t1_reject", 32'(reject), 32'd0);
        idle(3);

        // 2: latency of a clean press, then commit
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 1000, 0);
            if (i == 6) check("t2_pend_early", 32'(pending), 32'd0);
            if (i == 7) check("t2_pend_rise", 32'(pending), 32'd1);
        end
        idle(8);
        check("t2_duty_hold", 32'(duty_cycle), 32'd0);
        boundary();
        check("t2_duty_commit", 32'(duty_cycle), 32'd1000);
        check("t2_pend_clear", 32'(pending), 32'd0);

        // 3: bouncing press never qualifies; a long one qualifies once
        for (int i = 0; i < 3; i++) step(0, 0, 1, 7, 0);
        step(0, 1, 1, 7, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 7, 0);
        idle(8);
        check("t3_no_stage", 32'(pending), 32'd0);
        press(1, 3000);
        check("t3_staged", 32'(pending), 32'd1);
        boundary();

        // 4: deadtime sum must stay strictly below fs
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        press(1, 100);
        press(2, 60);
        press(3, 40);
        boundary();
        check("t4_reject", 32'(reject), 32'd1);
        check("t4_fs_kept", 32'(fs), 32'd4095);
        check("t4_pend", 32'(pending), 32'd0);
        step(0, 1, 0, 0, 0);
        check("t4_reject_pulse", 32'(reject), 32'd0);
        press(1, 100);
        press(2, 60);
        press(3, 39);
        boundary();
        check("t4_accept_fs", 32'(fs), 32'd100);
        check("t4_accept_dt2", 32'(deadtime2), 32'd39);

        // 5: duty above fs refused; matching fs accepted on one edge
        press(0, 200);
        press(1, 150);
        boundary();
        check("t5_reject", 32'(reject), 32'd1);
        check("t5_duty_kept", 32'(duty_cycle), 32'd0);
        press(0, 200);
        press(1, 250);
        boundary();
        check("t5_duty", 32'(duty_cycle), 32'd200);
        check("t5_fs", 32'(fs), 32'd250);

        // 6: stage and boundary together defer the commit
        for (int i = 1; i <= 8; i++) step(0, 0, 0, 77, i == 7);
        check("t6_deferred_pend", 32'(pending), 32'd1);
        check("t6_deferred_duty", 32'(duty_cycle), 32'd200);
        idle(8);
        boundary();
        check("t6_commit_duty", 32'(duty_cycle), 32'd77);
        for (int i = 0; i < 40; i++) step(0, 0, 3, 5, 0);
        idle(8);
        boundary();
        check("t6_held_dt2", 32'(deadtime2), 32'd5);
        check("t6_held_pend", 32'(pending), 32'd0);

        // Button held through a mid-operation reset
        for (int i = 0; i < 3; i++) step(0, 0, 2, 11, 0);
        step(1, 0, 2, 11, 0);
        step(1, 0, 2, 11, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 2, 11, 0);
        idle(8);

        // Random bursts of bouncing/holding with random boundaries
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            bit lvl;
            len = $urandom_range(1, 9);
            lvl = seg[0];
            for (int i = 0; i < len; i++) begin
                int v;
                v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 200);
                step(0, lvl, $urandom_range(0, 3), v, $urandom_range(0, 5) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
